// File: rtl/fmdll_pkg.sv
// fmdll_pkg -- shared definitions for the FMDLL delay-line select controller.
//   SEL_INJ / SEL_LOOP / SEL_LAST : delay-line input mux select codes
//   state_t                       : controller state encoding
//   sel_code()                    : state -> mux select mapping
package fmdll_pkg;

  localparam logic [1:0] SEL_INJ  = 2'b00;  // inject reference edge
  localparam logic [1:0] SEL_LOOP = 2'b10;  // recirculate
  localparam logic [1:0] SEL_LAST = 2'b01;  // hold for final edge

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INJECT,
    ST_LOOP,
    ST_LAST
  } state_t;

  function automatic logic [1:0] sel_code(input state_t st);
    logic [1:0] code;
    code = SEL_INJ;
    case (st)
      ST_IDLE:   code = SEL_INJ;
      ST_INJECT: code = SEL_INJ;
      ST_LOOP:   code = SEL_LOOP;
      ST_LAST:   code = SEL_LAST;
      default:   code = SEL_INJ;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/fmdll_nm_cnt.sv
// fmdll_nm_cnt -- nested wrap-around edge/period counter with shadowed limits.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   clr             : force both counters to 0
//   load            : start a frame: counters to 1/1, capture n_cfg/m_cfg
//   inc             : advance n_cnt, wrapping to 1 and bumping m_cnt at N
//   n_cfg, m_cfg    : requested edges per period / periods per frame (0 means 1)
//   n_cnt, m_cnt    : current 1-based edge / period index (0 when idle)
//   at_end          : n_cnt==N and m_cnt==M against the shadowed limits
// Priority: clr > load > inc > hold.
module fmdll_nm_cnt
  import fmdll_pkg::*;
#(
  parameter int unsigned N_W = 4,
  parameter int unsigned M_W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           load,
  input  logic           inc,
  input  logic [N_W-1:0] n_cfg,
  input  logic [M_W-1:0] m_cfg,
  output logic [N_W-1:0] n_cnt,
  output logic [M_W-1:0] m_cnt,
  output logic           at_end
);

  logic [N_W-1:0] n_lim;
  logic [M_W-1:0] m_lim;

  // Limits are captured only on load so mid-frame config changes wait for
  // the next frame; a zero configuration is promoted to 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_lim <= N_W'(1);
      m_lim <= M_W'(1);
    end else if (load) begin
      n_lim <= (n_cfg == '0) ? N_W'(1) : n_cfg;
      m_lim <= (m_cfg == '0) ? M_W'(1) : m_cfg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      n_cnt <= '0;
      m_cnt <= '0;
    end else if (load) begin
      n_cnt <= N_W'(1);
      m_cnt <= M_W'(1);
    end else if (inc) begin
      if (n_cnt == n_lim) begin
        n_cnt <= N_W'(1);
        m_cnt <= m_cnt + M_W'(1);
      end else begin
        n_cnt <= n_cnt + N_W'(1);
      end
    end
  end

  assign at_end = (n_cnt == n_lim) && (m_cnt == m_lim);

endmodule

// File: rtl/fmdll_sel_ctrl.sv
// fmdll_sel_ctrl -- delay-line input select controller for a frequency
// multiplying DLL. Injects a reference edge, recirculates it N*M-1 times and
// then holds the line until the next reference edge.
// Ports:
//   clk         : multiplied output clock, rising edge
//   rst_n       : synchronous active-low reset
//   en          : controller enable (low forces IDLE)
//   ext_edge    : one-cycle reference edge pulse, already in clk domain
//   n_cfg       : edges per period (0 treated as 1)
//   m_cfg       : periods per frame (0 treated as 1)
//   sel         : registered mux select (00 inject, 10 loop, 01 last)
//   n_cnt       : 1-based edge index within the period
//   m_cnt       : 1-based period index within the frame
//   frame_done  : one-cycle pulse in the first LAST cycle
//   sync_err    : sticky early/late reference error
// Optional feature: define SEL_SYNC_DET_EN to add sync_err and its detector.
module fmdll_sel_ctrl
  import fmdll_pkg::*;
#(
  parameter int unsigned N_W = 4,
  parameter int unsigned M_W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           ext_edge,
  input  logic [N_W-1:0] n_cfg,
  input  logic [M_W-1:0] m_cfg,
  output logic [1:0]     sel,
  output logic [N_W-1:0] n_cnt,
  output logic [M_W-1:0] m_cnt,
  output logic           frame_done
`ifdef SEL_SYNC_DET_EN
  ,
  output logic           sync_err
`endif
);

  state_t state;
  state_t state_next;
  logic   at_end;
  logic   cnt_clr;
  logic   cnt_load;
  logic   cnt_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (ext_edge) state_next = ST_INJECT;
        // A single-edge frame (N=1, M=1) skips LOOP entirely.
        ST_INJECT: state_next = at_end ? ST_LAST : ST_LOOP;
        // An early reference edge resynchronises the frame.
        ST_LOOP: begin
          if (ext_edge)    state_next = ST_INJECT;
          else if (at_end) state_next = ST_LAST;
        end
        ST_LAST:   if (ext_edge) state_next = ST_INJECT;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // Counter controls follow the next state so counts line up with sel.
  assign cnt_clr  = (state_next == ST_IDLE);
  assign cnt_load = (state_next == ST_INJECT);
  assign cnt_inc  = (state_next == ST_LOOP);

  fmdll_nm_cnt #(
    .N_W (N_W),
    .M_W (M_W)
  ) u_nm_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .load   (cnt_load),
    .inc    (cnt_inc),
    .n_cfg  (n_cfg),
    .m_cfg  (m_cfg),
    .n_cnt  (n_cnt),
    .m_cnt  (m_cnt),
    .at_end (at_end)
  );

  // sel is registered from the next state, so it always matches the state
  // register and changes one cycle after the triggering condition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel        <= SEL_INJ;
      frame_done <= 1'b0;
    end else begin
      sel        <= sel_code(state_next);
      frame_done <= (state != ST_LAST) && (state_next == ST_LAST);
    end
  end

`ifdef SEL_SYNC_DET_EN
  // Number of LAST cycles already completed (0 in the first LAST cycle).
  logic [1:0] last_dwell;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      sync_err   <= 1'b0;
      last_dwell <= '0;
    end else begin
      if (state == ST_LOOP && ext_edge) begin
        sync_err <= 1'b1;
      end
      // Staying in LAST for a third cycle means the reference is late.
      if (state == ST_LAST && state_next == ST_LAST && last_dwell != '0) begin
        sync_err <= 1'b1;
      end
      if (state == ST_LAST && state_next == ST_LAST) begin
        if (last_dwell != 2'd3) last_dwell <= last_dwell + 2'd1;
      end else begin
        last_dwell <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fmdll_sel_ctrl.sv
module tb_fmdll_sel_ctrl;

  localparam int N_W = 4;
  localparam int M_W = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           ext_edge = 1'b0;
  logic [N_W-1:0] n_cfg = '0;
  logic [M_W-1:0] m_cfg = '0;
  logic [1:0]     sel;
  logic [N_W-1:0] n_cnt;
  logic [M_W-1:0] m_cnt;
  logic           frame_done;
  logic           sync_err;

  always #5 clk = ~clk;

  fmdll_sel_ctrl #(
    .N_W (N_W),
    .M_W (M_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ext_edge   (ext_edge),
    .n_cfg      (n_cfg),
    .m_cfg      (m_cfg),
    .sel        (sel),
    .n_cnt      (n_cnt),
    .m_cnt      (m_cnt),
    .frame_done (frame_done)
`ifdef SEL_SYNC_DET_EN
    ,
    .sync_err   (sync_err)
`endif
  );

`ifndef SEL_SYNC_DET_EN
  assign sync_err = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]     sel;
    logic [N_W-1:0] n;
    logic [M_W-1:0] m;
    logic           fd;
    logic           se;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cur_n = 4;
  int cur_m = 2;

  // Reference model: frame position is a flat edge index e (1..N*M).
  int   mst = 0;   // 0 idle, 1 inject, 2 loop, 3 last
  int   e = 0;
  int   nm = 1;
  int   mm = 1;
  int   d = 0;     // LAST cycles including the current one
  logic m_fd = 1'b0;
  logic m_se = 1'b0;

  task automatic model_start(input int nc, input int mc);
    mst = 1;
    e   = 1;
    nm  = (nc == 0) ? 1 : nc;
    mm  = (mc == 0) ? 1 : mc;
  endtask

  task automatic model_step(input logic r, input logic en_i, input logic ext_i,
                            input int nc, input int mc);
    m_fd = 1'b0;
    if (!r || !en_i) begin
      mst = 0; e = 0; d = 0; m_se = 1'b0;
    end else begin
      case (mst)
        0: if (ext_i) model_start(nc, mc);
        1: begin
          if (e == nm * mm) begin mst = 3; d = 1; m_fd = 1'b1; end
          else begin mst = 2; e++; end
        end
        2: begin
          if (ext_i) begin m_se = 1'b1; model_start(nc, mc); end
          else if (e == nm * mm) begin mst = 3; d = 1; m_fd = 1'b1; end
          else e++;
        end
        default: begin
          if (ext_i) model_start(nc, mc);
          else begin d++; if (d > 2) m_se = 1'b1; end
        end
      endcase
    end
  endtask

  function automatic exp_t model_out();
    exp_t x;
    x.sel = (mst == 2) ? 2'b10 : (mst == 3) ? 2'b01 : 2'b00;
    x.n   = (e == 0) ? '0 : N_W'((e - 1) % nm + 1);
    x.m   = (e == 0) ? '0 : M_W'((e - 1) / nm + 1);
    x.fd  = m_fd;
`ifdef SEL_SYNC_DET_EN
    x.se  = m_se;
`else
    x.se  = 1'b0;
`endif
    return x;
  endfunction

  // Drive one cycle; outputs of the following cycle are visible on return.
  task automatic drive(input logic r, input logic en_i, input logic ext_i);
    @(negedge clk);
    rst_n    = r;
    en       = en_i;
    ext_edge = ext_i;
    n_cfg    = N_W'(cur_n);
    m_cfg    = M_W'(cur_m);
    model_step(r, en_i, ext_i, cur_n, cur_m);
    sb.push_back(model_out());
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: pops one expectation per clock, just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        checks++;
        if (sel !== x.sel) begin errors++; $display("FAIL sb_sel t=%0t got=%b exp=%b", $time, sel, x.sel); end
        checks++;
        if (n_cnt !== x.n) begin errors++; $display("FAIL sb_n_cnt t=%0t got=%0d exp=%0d", $time, n_cnt, x.n); end
        checks++;
        if (m_cnt !== x.m) begin errors++; $display("FAIL sb_m_cnt t=%0t got=%0d exp=%0d", $time, m_cnt, x.m); end
        checks++;
        if (frame_done !== x.fd) begin errors++; $display("FAIL sb_frame_done t=%0t got=%b exp=%b", $time, frame_done, x.fd); end
`ifdef SEL_SYNC_DET_EN
        checks++;
        if (sync_err !== x.se) begin errors++; $display("FAIL sb_sync_err t=%0t got=%b exp=%b", $time, sync_err, x.se); end
`endif
      end
    end
  end

  task automatic go_idle();
    drive(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cur_n = 4; cur_m = 2;
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    checks++;
    if ({sel, n_cnt, m_cnt, frame_done} !== '0) begin
      errors++; $display("FAIL reset_outputs got sel=%b n=%0d m=%0d fd=%b exp all 0", sel, n_cnt, m_cnt, frame_done);
    end
  endtask

  task automatic test_basic_frame();
    cur_n = 4; cur_m = 2;
    go_idle();
    drive(1'b1, 1'b1, 1'b1);  // cycle 0
    checks++;
    if (sel !== 2'b00 || n_cnt !== 4'd1 || m_cnt !== 2'd1) begin
      errors++; $display("FAIL basic_inject got sel=%b n=%0d m=%0d exp sel=00 n=1 m=1", sel, n_cnt, m_cnt);
    end
    for (int c = 1; c <= 8; c++) begin
      drive(1'b1, 1'b1, 1'b0);
      if (c <= 7) begin
        checks++;
        if (sel !== 2'b10) begin errors++; $display("FAIL basic_loop_sel cycle=%0d got=%b exp=10", c + 1, sel); end
      end
    end
    checks++;
    if (sel !== 2'b01 || frame_done !== 1'b1 || n_cnt !== 4'd4 || m_cnt !== 2'd2) begin
      errors++; $display("FAIL basic_last got sel=%b fd=%b n=%0d m=%0d exp sel=01 fd=1 n=4 m=2", sel, frame_done, n_cnt, m_cnt);
    end
    for (int c = 9; c <= 11; c++) drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (sel !== 2'b01 || frame_done !== 1'b0) begin
      errors++; $display("FAIL basic_last_hold got sel=%b fd=%b exp sel=01 fd=0", sel, frame_done);
    end
    drive(1'b1, 1'b1, 1'b1);  // cycle 12
    checks++;
    if (sel !== 2'b00 || n_cnt !== 4'd1 || m_cnt !== 2'd1) begin
      errors++; $display("FAIL basic_reinject got sel=%b n=%0d m=%0d exp sel=00 n=1 m=1", sel, n_cnt, m_cnt);
    end
  endtask

  task automatic test_early_resync();
    cur_n = 4; cur_m = 2;
    go_idle();
    drive(1'b1, 1'b1, 1'b1);
    for (int c = 1; c <= 4; c++) drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);  // cycle 5, in LOOP
    checks++;
    if (sel !== 2'b00 || n_cnt !== 4'd1 || m_cnt !== 2'd1) begin
      errors++; $display("FAIL early_resync got sel=%b n=%0d m=%0d exp sel=00 n=1 m=1", sel, n_cnt, m_cnt);
    end
`ifdef SEL_SYNC_DET_EN
    checks++;
    if (sync_err !== 1'b1) begin errors++; $display("FAIL early_sync_err got=%b exp=1", sync_err); end
`endif
  endtask

  task automatic test_cfg_change();
    cur_n = 4; cur_m = 2;
    go_idle();
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    cur_n = 6;
    for (int c = 3; c <= 8; c++) drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (frame_done !== 1'b1 || n_cnt !== 4'd4 || m_cnt !== 2'd2) begin
      errors++; $display("FAIL cfg_old_frame got fd=%b n=%0d m=%0d exp fd=1 n=4 m=2", frame_done, n_cnt, m_cnt);
    end
    drive(1'b1, 1'b1, 1'b1);  // cycle 9
    for (int c = 10; c <= 21; c++) drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (frame_done !== 1'b1 || n_cnt !== 4'd6 || m_cnt !== 2'd2 || sel !== 2'b01) begin
      errors++; $display("FAIL cfg_new_frame got fd=%b n=%0d m=%0d sel=%b exp fd=1 n=6 m=2 sel=01", frame_done, n_cnt, m_cnt, sel);
    end
  endtask

  task automatic test_reset_midframe();
    int fd_seen;
    cur_n = 4; cur_m = 2;
    go_idle();
    drive(1'b1, 1'b1, 1'b1);
    for (int c = 1; c <= 4; c++) drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);  // cycle 5
    checks++;
    if (sel !== 2'b00 || n_cnt !== 4'd0 || m_cnt !== 2'd0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL rst_mid got sel=%b n=%0d m=%0d fd=%b exp all 0", sel, n_cnt, m_cnt, frame_done);
    end
    fd_seen = 0;
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, 1'b1, 1'b0);
      if (frame_done === 1'b1 || sel !== 2'b00) fd_seen++;
    end
    checks++;
    if (fd_seen != 0) begin errors++; $display("FAIL rst_mid_abandon got=%0d non-idle cycles exp=0", fd_seen); end
  endtask

  task automatic test_zero_cfg();
    cur_n = 0; cur_m = 0;
    go_idle();
    drive(1'b1, 1'b1, 1'b1);
    checks++;
    if (sel !== 2'b00 || n_cnt !== 4'd1 || m_cnt !== 2'd1 || frame_done !== 1'b0) begin
      errors++; $display("FAIL zero_inject got sel=%b n=%0d m=%0d fd=%b exp 00/1/1/0", sel, n_cnt, m_cnt, frame_done);
    end
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (sel !== 2'b01 || n_cnt !== 4'd1 || m_cnt !== 2'd1 || frame_done !== 1'b1) begin
      errors++; $display("FAIL zero_last got sel=%b n=%0d m=%0d fd=%b exp 01/1/1/1", sel, n_cnt, m_cnt, frame_done);
    end
  endtask

  task automatic test_en_low();
    cur_n = 4; cur_m = 2;
    go_idle();
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1);  // en low wins over ext_edge
    checks++;
    if (sel !== 2'b00 || n_cnt !== 4'd0 || m_cnt !== 2'd0) begin
      errors++; $display("FAIL en_low got sel=%b n=%0d m=%0d exp 00/0/0", sel, n_cnt, m_cnt);
    end
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (sel !== 2'b00 || n_cnt !== 4'd0) begin
      errors++; $display("FAIL en_low_ignored_edge got sel=%b n=%0d exp 00/0", sel, n_cnt);
    end
  endtask

  task automatic test_random();
    logic r, en_i, ext_i;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 29) == 0) begin
        cur_n = $urandom_range(0, 15);
        cur_m = $urandom_range(0, 3);
      end
      r     = ($urandom_range(0, 99) != 0);
      en_i  = ($urandom_range(0, 39) != 0);
      ext_i = ($urandom_range(0, 11) == 0);
      drive(r, en_i, ext_i);
    end
    cur_n = 15; cur_m = 3;
    go_idle();
    drive(1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 48; c++) drive(1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_early_resync();
    test_cfg_change();
    test_reset_midframe();
    test_zero_cfg();
    test_en_low();
    test_random();
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got=%0d pending exp=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fmdll_sel_ctrl.md
FMDLL_SEL_CTRL -- requirements
Module: fmdll_sel_ctrl

Interface
REQ-001 SHALL have parameter N_W, default 4, width of per-period edge count N.
REQ-002 SHALL have parameter M_W, default 2, width of period count M.
REQ-003 SHALL have port clk  in  1  multiplied output clock (clk_out domain); all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  in  1  controller enable.
REQ-006 SHALL have port ext_edge  in  1  one-cycle pulse marking a reference edge, pre-synchronised to clk.
REQ-007 SHALL have port n_cfg  in  N_W  edges per period.
REQ-008 SHALL have port m_cfg  in  M_W  periods per frame.
REQ-009 SHALL have port sel  out  2  delay-line input mux select, registered.
REQ-010 SHALL have port n_cnt  out  N_W  current edge index, 1-based.
REQ-011 SHALL have port m_cnt  out  M_W  current period index, 1-based.
REQ-012 SHALL have port frame_done  out  1  one-cycle pulse on entry to LAST.
REQ-013 SHALL have port sync_err  out  1  sticky early/late reference error (SEL_SYNC_DET_EN only).

Function
REQ-014 SHALL encode sel as INJ=2'b00 (inject reference edge), LOOP=2'b10 (recirculate), LAST=2'b01 (hold for final edge).
REQ-015 SHALL implement states IDLE, INJECT, LOOP, LAST; sel is INJ in IDLE and INJECT, LOOP in LOOP, LAST in LAST.
REQ-016 IDLE -> INJECT when en & ext_edge; otherwise remain in IDLE with counters 0.
REQ-017 INJECT SHALL last exactly one cycle, load n_cnt=1, m_cnt=1, shadow-register n_cfg/m_cfg, then go to LOOP.
REQ-018 In LOOP, n_cnt SHALL increment each cycle; on n_cnt==N it wraps to 1 and m_cnt increments.
REQ-019 LOOP -> LAST when n_cnt==N and m_cnt==M (shadowed values); frame_done pulses that cycle.
REQ-020 LAST SHALL hold sel=LAST and counters until ext_edge, then go to INJECT next cycle.
REQ-021 n_cfg==0 or m_cfg==0 SHALL be treated as 1; N=1,M=1 gives INJECT->LAST with no LOOP cycle.
REQ-022 Changes to n_cfg/m_cfg mid-frame SHALL take effect only at the next INJECT.
REQ-023 ext_edge while in LOOP (early) SHALL force INJECT next cycle (resync).
REQ-024 en deasserted in any state SHALL force IDLE next cycle; ext_edge in the same cycle is ignored.
REQ-025 All outputs SHALL be registered; sel changes one cycle after the triggering condition.

Reset
REQ-026 On rst_n==0 at a clk edge: state IDLE, sel=2'b00, n_cnt=0, m_cnt=0, frame_done=0, sync_err=0.
REQ-027 Reset mid-frame SHALL abandon the frame with no frame_done pulse.

Configuration
REQ-028 Macro SEL_SYNC_DET_EN defined: sync_err SHALL set on early ext_edge in LOOP, or on en-high LAST dwell exceeding 2 cycles; cleared only by reset or en low.
REQ-029 Macro SEL_SYNC_DET_EN undefined: sync_err port and detection logic SHALL be absent; resync of REQ-023 still applies.

Structure
REQ-030 Shared package fmdll_pkg SHALL hold sel codes (SEL_INJ, SEL_LOOP, SEL_LAST) and the state enum.
REQ-031 One sub-module fmdll_nm_cnt (nested wrap-around N/M counter with shadow registers) SHALL be instantiated.

Verification
REQ-032 N=4,M=2, en=1, ext_edge at cycle 0 -> sel 00 at cycle 1, 10 for cycles 2-8, 01 at cycle 9 with frame_done=1.
REQ-033 In LAST, ext_edge at cycle 12 -> sel=00 at cycle 13, n_cnt=1, m_cnt=1.
REQ-034 N=4,M=2, ext_edge at cycle 5 (LOOP) -> INJECT at cycle 6; sync_err=1 if SEL_SYNC_DET_EN defined.
REQ-035 n_cfg changed 4->6 at cycle 3 -> current frame still wraps at 4; next frame wraps at 6.
REQ-036 rst_n=0 at cycle 5 of a frame -> next cycle sel=00, n_cnt=0, m_cnt=0, no frame_done.
REQ-037 n_cfg=0, m_cfg=0 -> INJECT then LAST directly, frame_done one cycle after INJECT.
